adder_result_collector: RTL and testbench
=========================================

Name: adder_result_collector

Overview:
- Downstream stage of the 64-bit registered fast adder.
- Tracks each operation issued to the adder and aligns it with the adder's fixed 2-cycle latency.
- Captures sum and carry when they appear, derives status flags (carry/borrow, zero, negative, signed overflow), and buffers results in a small FIFO with a valid/ready output handshake.
- Throttles issue with a credit check so no adder result is ever dropped.

Parameters:
- W, 64, operand/sum width; must match the adder.
- LAT, 2, edges from the issue handshake to the adder's registered sum being stable.
- DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  upstream presents an operation to the adder this cycle.
- issue_ready  out  1  collector can accept an issue; issue is accepted when issue_valid and issue_ready are both high.
- issue_op  in  1  0 = add, 1 = subtract (same encoding as the adder's operation input).
- issue_a_msb  in  1  bit W-1 of operand a.
- issue_b_msb  in  1  bit W-1 of the original operand b, before negation.
- issue_b_zero  in  1  original operand b equals zero.
- add_sum  in  W  adder registered sum.
- add_carry  in  1  adder registered carry.
- res_valid  out  1  FIFO head holds a result.
- res_ready  in  1  consumer accepts the head.
- res_sum  out  W  head sum.
- res_cb  out  1  add: carry out; sub: borrow (unsigned a < b).
- res_zero  out  1  res_sum == 0.
- res_neg  out  1  res_sum[W-1].
- res_ovf  out  1  signed overflow.
- res_op  out  1  operation of the head entry.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - clears the tag pipeline valids, FIFO read/write pointers, count, and FIFO storage;
  - after reset: res_valid=0, res_sum=0, all res_* flags=0, issue_ready=1.
- Reset mid-operation:
  - in-flight tags and stored entries are discarded;
  - adder outputs arriving after reset are ignored, because no tag is valid.
- Tag pipeline:
  - LAT-stage shift register of {valid, op, a_msb, b_msb, b_zero};
  - stage 0 loads the accepted issue, or a bubble, every edge.
- Capture:
  - an issue accepted at edge k is written to the FIFO at edge k+LAT, sampling add_sum and add_carry at that edge;
  - the last tag stage valid implies a write.
- Flags are computed at write time and stored with the entry:
  - zero = ~|add_sum; neg = add_sum[W-1].
  - Add: cb = add_carry; ovf = (a_msb==b_msb) & (sum_msb!=a_msb).
  - Sub: cb = b_zero ? 0 : ~add_carry. The adder negates b as ~b+1, which yields carry 0 when b==0, so b_zero overrides.
  - Sub: ovf = (a_msb!=b_msb) & (sum_msb!=a_msb). This covers b = most-negative value.
- Credit and flow control:
  - inflight = number of valid tag stages;
  - issue_ready = (count + inflight) < DEPTH, computed from registered state only; a same-cycle pop does not raise issue_ready (no bypass);
  - a FIFO write therefore never finds the FIFO full.
- Output handshake:
  - res_valid = (count != 0); res_* show the head entry combinationally from storage;
  - pop on res_valid & res_ready;
  - res_* are held stable while res_valid=1 and res_ready=0.
- Simultaneous write and pop in one edge: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; order is strictly FIFO.
- Back-to-back issues sustain one result per cycle when res_ready is held high.
- issue_valid while issue_ready=0: not accepted; no tag is created, and upstream must not advance the adder inputs.

Test Plan:
- Add 5+3 (op=0, msbs=0): at edge k+2, res_valid=1, res_sum=8, cb=0, zero=0, neg=0, ovf=0.
- Sub 5-5: adder carry=1 -> res_sum=0, zero=1, cb=0 (no borrow), ovf=0.
- Sub 3-5: adder sum=0xFFFF_FFFF_FFFF_FFFE, carry=0 -> cb=1, neg=1, ovf=0. Then sub 7-0 (b_zero=1, carry=0) -> res_sum=7, cb=0.
- Add 0x7FFF_FFFF_FFFF_FFFF+1 -> res_sum=0x8000_0000_0000_0000, ovf=1, neg=1. Sub 0-0x8000_0000_0000_0000 -> ovf=1.
- res_ready=0, issue_valid held high with 6 distinct ops:
  - exactly 4 are accepted, then issue_ready=0;
  - FIFO reaches count 4 with no lost result;
  - res_ready=1 then drains all 4 in issue order, one per cycle, and issue_ready returns high.
- Issue 2 ops, assert rst one cycle before their capture edge: no entry is written, res_valid stays 0, issue_ready=1 after reset.

Source files
------------

// File: rtl/adder_result_collector_if.sv
// Issue, adder-return and result channels between the upstream issuer,
// the 64-bit registered adder and the result collector.
interface adder_result_collector_if #(
   parameter int W = 64
);
   logic         issue_valid;
   logic         issue_ready;
   logic         issue_op;
   logic         issue_a_msb;
   logic         issue_b_msb;
   logic         issue_b_zero;
   logic [W-1:0] add_sum;
   logic         add_carry;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_sum;
   logic         res_cb;
   logic         res_zero;
   logic         res_neg;
   logic         res_ovf;
   logic         res_op;

   modport slave (
      input  issue_valid, issue_op, issue_a_msb, issue_b_msb, issue_b_zero,
      input  add_sum, add_carry, res_ready,
      output issue_ready, res_valid, res_sum, res_cb, res_zero, res_neg, res_ovf, res_op
   );

   modport master (
      output issue_valid, issue_op, issue_a_msb, issue_b_msb, issue_b_zero,
      output add_sum, add_carry, res_ready,
      input  issue_ready, res_valid, res_sum, res_cb, res_zero, res_neg, res_ovf, res_op
   );
endinterface

// File: rtl/adder_result_collector.sv
// Aligns issued operations with the adder's fixed latency, derives status flags
// and buffers results in a credit-protected FIFO with a valid/ready output.
module adder_result_collector #(
   parameter int W     = 64,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input logic                      clk,
   input logic                      rst,
   adder_result_collector_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(DEPTH + LAT + 1);

   logic [LAT-1:0] tag_valid_reg;
   logic [LAT-1:0] tag_op_reg;
   logic [LAT-1:0] tag_a_msb_reg;
   logic [LAT-1:0] tag_b_msb_reg;
   logic [LAT-1:0] tag_b_zero_reg;

   logic [W-1:0]   sum_mem  [DEPTH];
   logic [4:0]     flag_mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [CW-1:0]  count_reg;

   logic           accept;
   logic           wr_en;
   logic           pop;
   logic           sum_msb;
   logic           cb_next;
   logic           ovf_next;
   logic [SW-1:0]  inflight;
   logic [SW-1:0]  credit;

   assign accept = bus.issue_valid & bus.issue_ready;

   // Stage 0 takes the accepted issue or a bubble on every edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid_reg  <= '0;
         tag_op_reg     <= '0;
         tag_a_msb_reg  <= '0;
         tag_b_msb_reg  <= '0;
         tag_b_zero_reg <= '0;
      end else begin
         tag_valid_reg[0]  <= accept;
         tag_op_reg[0]     <= bus.issue_op;
         tag_a_msb_reg[0]  <= bus.issue_a_msb;
         tag_b_msb_reg[0]  <= bus.issue_b_msb;
         tag_b_zero_reg[0] <= bus.issue_b_zero;
         for (int i = 1; i < LAT; i++) begin
            tag_valid_reg[i]  <= tag_valid_reg[i-1];
            tag_op_reg[i]     <= tag_op_reg[i-1];
            tag_a_msb_reg[i]  <= tag_a_msb_reg[i-1];
            tag_b_msb_reg[i]  <= tag_b_msb_reg[i-1];
            tag_b_zero_reg[i] <= tag_b_zero_reg[i-1];
         end
      end
   end

   assign wr_en   = tag_valid_reg[LAT-1];
   assign pop     = (count_reg != '0) & bus.res_ready;
   assign sum_msb = bus.add_sum[W-1];

   // A subtract with b==0 yields adder carry 0 although nothing is borrowed.
   always_comb begin
      cb_next  = 1'b0;
      ovf_next = 1'b0;
      if (tag_op_reg[LAT-1]) begin
         cb_next  = tag_b_zero_reg[LAT-1] ? 1'b0 : ~bus.add_carry;
         ovf_next = (tag_a_msb_reg[LAT-1] != tag_b_msb_reg[LAT-1]) &
                    (sum_msb != tag_a_msb_reg[LAT-1]);
      end else begin
         cb_next  = bus.add_carry;
         ovf_next = (tag_a_msb_reg[LAT-1] == tag_b_msb_reg[LAT-1]) &
                    (sum_msb != tag_a_msb_reg[LAT-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sum_mem[i]  <= '0;
            flag_mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            sum_mem[wr_ptr_reg]  <= bus.add_sum;
            flag_mem[wr_ptr_reg] <= {tag_op_reg[LAT-1], cb_next, ~|bus.add_sum,
                                     sum_msb, ovf_next};
            wr_ptr_reg           <= wr_ptr_reg + AW'(1);
         end
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (wr_en && !pop)
            count_reg <= count_reg + CW'(1);
         else if (!wr_en && pop)
            count_reg <= count_reg - CW'(1);
      end
   end

   // Credit counts every tag still in flight, so a capture never meets a full FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++)
         inflight = inflight + SW'(tag_valid_reg[i]);
   end

   assign credit          = SW'(count_reg) + inflight;
   assign bus.issue_ready = credit < SW'(DEPTH);

   assign bus.res_valid = (count_reg != '0);
   assign bus.res_sum   = sum_mem[rd_ptr_reg];
   assign bus.res_op    = flag_mem[rd_ptr_reg][4];
   assign bus.res_cb    = flag_mem[rd_ptr_reg][3];
   assign bus.res_zero  = flag_mem[rd_ptr_reg][2];
   assign bus.res_neg   = flag_mem[rd_ptr_reg][1];
   assign bus.res_ovf   = flag_mem[rd_ptr_reg][0];
endmodule

// File: tb/tb_adder_result_collector.sv
// Directed and randomized bench for adder_result_collector, with a two-stage
// adder model feeding the DUT and an arithmetic reference scoreboard.
module tb_adder_result_collector;
   localparam int W     = 64;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cb;
      logic         zero;
      logic         neg;
      logic         ovf;
      logic         op;
      logic [31:0]  wr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_result_collector_if #(.W(W)) bus ();
   adder_result_collector #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = 0;
   exp_t        q[$];
   logic [W-1:0] cur_a = '0;
   logic [W-1:0] cur_b = '0;
   logic         cur_op = 1'b0;
   logic [W:0]   adder_s1 = '0;
   logic [W:0]   adder_s2 = '0;

   assign bus.issue_op     = cur_op;
   assign bus.issue_a_msb  = cur_a[W-1];
   assign bus.issue_b_msb  = cur_b[W-1];
   assign bus.issue_b_zero = (cur_b == '0);
   assign bus.add_sum      = adder_s2[W-1:0];
   assign bus.add_carry    = adder_s2[W];

   // The adder negates b as ~b+1 inside W bits before adding.
   function automatic logic [W:0] adder_fn(logic [W-1:0] a, logic [W-1:0] b, logic op);
      logic [W-1:0] nb;
      nb = op ? (~b + 1'b1) : b;
      return {1'b0, a} + {1'b0, nb};
   endfunction

   function automatic exp_t ref_model(logic [W-1:0] a, logic [W-1:0] b, logic op,
                                      logic [31:0] wr);
      exp_t r;
      logic signed [W:0] sr;
      logic [W:0] ur;
      if (op) begin
         r.sum = a - b;
         r.cb  = (a < b);
         sr    = $signed({a[W-1], a}) - $signed({b[W-1], b});
      end else begin
         ur    = {1'b0, a} + {1'b0, b};
         r.sum = ur[W-1:0];
         r.cb  = ur[W];
         sr    = $signed({a[W-1], a}) + $signed({b[W-1], b});
      end
      r.ovf  = sr[W] ^ sr[W-1];
      r.zero = (r.sum == '0);
      r.neg  = r.sum[W-1];
      r.op   = op;
      r.wr   = wr;
      return r;
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bus.issue_valid && bus.issue_ready)
         adder_s1 <= adder_fn(cur_a, cur_b, cur_op);
      adder_s2 <= adder_s1;
      if (rst)
         q.delete();
      else if (bus.issue_valid && bus.issue_ready)
         q.push_back(ref_model(cur_a, cur_b, cur_op, cyc + LAT));
   end

   task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks at the falling edge, then advances past the next rising edge.
   task automatic step(output bit acc);
      bit exp_v;
      @(negedge clk);
      acc = bus.issue_valid & bus.issue_ready;
      chk("issue_ready", {63'd0, bus.issue_ready}, {63'd0, q.size() < DEPTH});
      exp_v = (q.size() != 0) && (q[0].wr <= cyc);
      chk("res_valid", {63'd0, bus.res_valid}, {63'd0, exp_v});
      if (exp_v) begin
         chk("res_sum", bus.res_sum, q[0].sum);
         chk("res_cb", {63'd0, bus.res_cb}, {63'd0, q[0].cb});
         chk("res_zero", {63'd0, bus.res_zero}, {63'd0, q[0].zero});
         chk("res_neg", {63'd0, bus.res_neg}, {63'd0, q[0].neg});
         chk("res_ovf", {63'd0, bus.res_ovf}, {63'd0, q[0].ovf});
         chk("res_op", {63'd0, bus.res_op}, {63'd0, q[0].op});
         if (bus.res_ready) begin
            $display("pop op=%0d sum=%h cb=%0d z=%0d n=%0d v=%0d", q[0].op, q[0].sum,
                     q[0].cb, q[0].zero, q[0].neg, q[0].ovf);
            void'(q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic direct(string tag, logic [W-1:0] a, logic [W-1:0] b, logic op,
                         logic [W-1:0] e_sum, logic e_cb, logic e_zero, logic e_neg,
                         logic e_ovf);
      bit acc;
      bus.res_ready   = 1'b0;
      cur_a           = a;
      cur_b           = b;
      cur_op          = op;
      bus.issue_valid = 1'b1;
      step(acc);
      chk({tag, "_accept"}, {63'd0, acc}, 64'd1);
      bus.issue_valid = 1'b0;
      step(acc);
      step(acc);
      chk({tag, "_valid"}, {63'd0, bus.res_valid}, 64'd1);
      chk({tag, "_sum"}, bus.res_sum, e_sum);
      chk({tag, "_cb"}, {63'd0, bus.res_cb}, {63'd0, e_cb});
      chk({tag, "_zero"}, {63'd0, bus.res_zero}, {63'd0, e_zero});
      chk({tag, "_neg"}, {63'd0, bus.res_neg}, {63'd0, e_neg});
      chk({tag, "_ovf"}, {63'd0, bus.res_ovf}, {63'd0, e_ovf});
      $display("direct %s op=%0d a=%h b=%h sum=%h", tag, op, a, b, bus.res_sum);
      bus.res_ready = 1'b1;
      step(acc);
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(5))
         0:       return '0;
         1:       return {1'b1, {(W-1){1'b0}}};
         2:       return {1'b0, {(W-1){1'b1}}};
         3:       return '1;
         4:       return W'($urandom_range(7));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      bit acc;
      int n_acc;
      bus.issue_valid = 1'b0;
      bus.res_ready   = 1'b0;
      rst             = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_valid", {63'd0, bus.res_valid}, 64'd0);
      chk("reset_sum", bus.res_sum, 64'd0);
      chk("reset_flags", {59'd0, bus.res_cb, bus.res_zero, bus.res_neg, bus.res_ovf,
                          bus.res_op}, 64'd0);
      chk("reset_ready", {63'd0, bus.issue_ready}, 64'd1);

      direct("add5p3", 64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      direct("sub5m5", 64'd5, 64'd5, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      direct("sub3m5", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
      direct("sub7m0", 64'd7, 64'd0, 1'b1, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      direct("addmax", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000,
             1'b0, 1'b0, 1'b1, 1'b1);
      direct("sub0mmin", 64'd0, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000,
             1'b1, 1'b0, 1'b1, 1'b1);

      // Fill with the consumer stalled: only DEPTH issues may be accepted.
      bus.res_ready   = 1'b0;
      n_acc           = 0;
      cur_a           = 64'd100;
      cur_b           = 64'd1;
      cur_op          = 1'b0;
      bus.issue_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(acc);
         if (acc) begin
            n_acc++;
            if (n_acc < 6) begin
               cur_a  = 64'd100 + 64'(n_acc);
               cur_b  = 64'(n_acc * 3);
               cur_op = n_acc[0];
            end else begin
               bus.issue_valid = 1'b0;
            end
         end
      end
      chk("fill_accepted", 64'(n_acc), 64'(DEPTH));
      chk("fill_ready_low", {63'd0, bus.issue_ready}, 64'd0);
      chk("fill_valid", {63'd0, bus.res_valid}, 64'd1);
      bus.issue_valid = 1'b0;
      bus.res_ready   = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         step(acc);
      chk("drain_valid", {63'd0, bus.res_valid}, 64'd0);
      chk("drain_ready", {63'd0, bus.issue_ready}, 64'd1);

      // Reset lands one edge before the first capture.
      bus.res_ready   = 1'b0;
      cur_a           = 64'd11;
      cur_b           = 64'd22;
      cur_op          = 1'b0;
      bus.issue_valid = 1'b1;
      step(acc);
      cur_a = 64'd33;
      rst   = 1'b1;
      step(acc);
      rst             = 1'b0;
      bus.issue_valid = 1'b0;
      for (int i = 0; i < 4; i++)
         step(acc);
      chk("rstmid_valid", {63'd0, bus.res_valid}, 64'd0);
      chk("rstmid_ready", {63'd0, bus.issue_ready}, 64'd1);
      chk("rstmid_sum", bus.res_sum, 64'd0);

      // Randomized traffic; operands only advance after an accepted issue.
      cur_a  = rand_operand();
      cur_b  = rand_operand();
      cur_op = 1'($urandom_range(1));
      for (int i = 0; i < 400; i++) begin
         bus.issue_valid = ($urandom_range(3) != 0);
         bus.res_ready   = (i >= 200 && i < 260) ? 1'b1 : ($urandom_range(2) != 0);
         step(acc);
         if (acc) begin
            cur_a  = rand_operand();
            cur_b  = rand_operand();
            cur_op = 1'($urandom_range(1));
         end
      end
      bus.issue_valid = 1'b0;
      bus.res_ready   = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++)
         step(acc);
      chk("final_valid", {63'd0, bus.res_valid}, 64'd0);
      chk("final_ready", {63'd0, bus.issue_ready}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
